// File: rtl/shift_right_sequencer.sv
// Load/shift/done sequencer driving an N-bit shift-right register.
// Optional SHIFT_PAUSE_EN adds a pause input that stalls the SHIFT phase.
//
// state | meaning
// IDLE  | waiting for start; captures word and clamped shift count
// LOAD  | one-cycle load_en pulse to the register
// SHIFT | shift_en asserted; counter tracks shifts still owed
// DONE  | one-cycle done pulse, then back to IDLE
module shift_right_sequencer #(
    parameter  int N     = 14,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
`ifdef SHIFT_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [N-1:0]     data_in,
    input  logic [CNT_W-1:0] shift_amt,
    output logic [N-1:0]     load_data,
    output logic             load_en,
    output logic             shift_en,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     load_data_q, load_data_d;
    logic             load_en_q, load_en_d;
    logic             shift_en_q, shift_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pause_w;

`ifdef SHIFT_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d     = LOAD;
                    load_data_d = data_in;
                    cnt_d       = (shift_amt > N_CNT) ? N_CNT : shift_amt;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (shift_en_q) begin
                    // Count only cycles that really shifted, so a pause never loses a shift.
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        load_en_d  = (state_d == LOAD);
        shift_en_d = (state_d == SHIFT) && !(pause_w && (state_q == SHIFT));
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            load_data_q <= '0;
            load_en_q   <= 1'b0;
            shift_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            load_en_q   <= load_en_d;
            shift_en_q  <= shift_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign load_data = load_data_q;
    assign load_en   = load_en_q;
    assign shift_en  = shift_en_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_shift_right_sequencer.sv
// Scoreboard bench for shift_right_sequencer: stimulus queues expectations,
// a negedge monitor models the shift register and checks each load/done.
module tb_shift_right_sequencer;

    localparam int N     = 14;
    localparam int CNT_W = $clog2(N + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
`ifdef SHIFT_PAUSE_EN
    logic             pause = 1'b0;
`endif
    logic [N-1:0]     data_in = '0;
    logic [CNT_W-1:0] shift_amt = '0;
    logic [N-1:0]     load_data;
    logic             load_en;
    logic             shift_en;
    logic             busy;
    logic             done;

    shift_right_sequencer #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
`ifdef SHIFT_PAUSE_EN
        .pause     (pause),
`endif
        .data_in   (data_in),
        .shift_amt (shift_amt),
        .load_data (load_data),
        .load_en   (load_en),
        .shift_en  (shift_en),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           shifts;
        logic [N-1:0] regv;
        int           lat;
    } exp_t;

    logic [N-1:0] exp_load[$];
    exp_t         exp_done[$];

    int tests = 0, fails = 0;
    int mon_tests = 0, mon_fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mcheck(input string name, input logic [31:0] act, input logic [31:0] exp);
        mon_tests++;
        if (act !== exp) begin
            mon_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: register model plus per-sequence shift count and latency.
    int           cyc = 0;
    int           load_cyc = 0;
    int           shifts = 0;
    logic [N-1:0] reg_m = '0;
    logic [N-1:0] e_load;
    exp_t         e_done;

    always @(negedge clk) begin
        if (reset) begin
            cyc++;
            if (load_en || shift_en)
                mcheck("load_shift_exclusive", {31'b0, load_en && shift_en}, 32'd0);
            if (load_en) begin
                if (exp_load.size() == 0) begin
                    mcheck("unexpected_load_en", 32'd1, 32'd0);
                end else begin
                    e_load = exp_load.pop_front();
                    mcheck("load_data", {18'b0, load_data}, {18'b0, e_load});
                    reg_m = e_load;
                end
                load_cyc = cyc;
                shifts   = 0;
            end
            if (shift_en) begin
                reg_m = reg_m >> 1;
                shifts++;
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    mcheck("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e_done = exp_done.pop_front();
                    mcheck("shift_count", shifts, e_done.shifts);
                    mcheck("done_latency", cyc - load_cyc, e_done.lat);
                    mcheck("reg_model", {18'b0, reg_m}, {18'b0, e_done.regv});
                end
            end
        end
    end

    task automatic issue(input logic [N-1:0] d, input logic [CNT_W-1:0] a);
        @(posedge clk); #1;
        data_in = d; shift_amt = a; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; data_in = ~d; shift_amt = '0;
        @(negedge clk);
        check("load_en_latency", {31'b0, load_en}, 32'd1);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", {31'b0, seen}, 32'd1);
        #1;
        check("scoreboard_drained", exp_done.size(), 32'd0);
    endtask

    task automatic run_seq(input logic [N-1:0] d, input logic [CNT_W-1:0] a,
                           input logic [N-1:0] exp_reg, input int exp_shifts);
        exp_t e;
        e.shifts = exp_shifts;
        e.regv   = exp_reg;
        e.lat    = exp_shifts + 1;
        exp_load.push_back(d);
        exp_done.push_back(e);
        issue(d, a);
        wait_done(40);
    endtask

    task automatic wait_shifts(input int target);
        int n = 0;
        for (int i = 0; i < 40 && n < target; i++) begin
            @(negedge clk);
            if (shift_en) n++;
        end
        check("shift_wait", n, target);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_load_data", {18'b0, load_data}, 32'd0);
        check("reset_ctrl", {28'b0, load_en, shift_en, busy, done}, 32'd0);
        reset = 1'b1;

        run_seq(14'b10101000000011, 4'd10, 14'b00000000001010, 10);
        // Issued straight after the previous done: back-to-back acceptance.
        run_seq(14'h1234, 4'd0,  14'h1234, 0);
        run_seq(14'h3FFF, 4'd15, 14'h0000, 14);
        run_seq(14'h2A5B, 4'd3,  14'h054B, 3);
        run_seq(14'h2000, 4'd14, 14'h0000, 14);
        run_seq(14'h0003, 4'd1,  14'h0001, 1);

        // abort wins over a simultaneous start in IDLE
        @(posedge clk); #1;
        data_in = 14'h0101; shift_amt = 4'd2; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_idle_no_load", {30'b0, load_en, busy}, 32'd0);

        // abort in the 4th SHIFT cycle; start pulses while busy are ignored
        exp_load.push_back(14'h1555);
        issue(14'h1555, 4'd8);
        wait_shifts(2);
        start = 1'b1; data_in = 14'h0AAA; shift_amt = 4'd3;
        wait_shifts(1);
        start = 1'b0;
        wait_shifts(1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_outputs", {29'b0, busy, shift_en, done}, 32'd0);
        check("abort_keeps_load_data", {18'b0, load_data}, {18'b0, 14'h1555});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_done", {30'b0, done, busy}, 32'd0);
        end

        // async reset during SHIFT
        exp_load.push_back(14'h3C3C);
        issue(14'h3C3C, 4'd10);
        wait_shifts(3);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_load_data", {18'b0, load_data}, 32'd0);
        check("async_rst_ctrl", {28'b0, load_en, shift_en, busy, done}, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        run_seq(14'h0F0F, 4'd4, 14'h00F0, 4);

`ifdef SHIFT_PAUSE_EN
        begin
            exp_t ep;
            ep.shifts = 5;
            ep.regv   = 14'h01FF;
            ep.lat    = 5 + 1 + 3;
            exp_load.push_back(14'h3FFF);
            exp_done.push_back(ep);
            issue(14'h3FFF, 4'd5);
            wait_shifts(1);
            pause = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            pause = 1'b0;
            wait_done(40);
        end
`endif

        repeat (3) @(negedge clk);
        check("load_queue_drained", exp_load.size(), 32'd0);
        tests = tests + mon_tests;
        fails = fails + mon_fails;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
